// File: rtl/artau_pkg.sv
// Shared encodings, physical constants and range helper for the burst tracker.
package artau_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT   = 2'd1,
    LISTEN = 2'd2,
    STATUS = 2'd3
  } artau_state_e;

  localparam int unsigned SPEED_OF_LIGHT_HALF_M_PER_US = 150;
  localparam int unsigned US_PER_S                     = 1_000_000;

  // Round-trip echo delay in cycles -> one-way range in metres.
  function automatic logic [63:0] range_from_cycles(input logic [31:0] cycles,
                                                    input logic [31:0] clk_period_us);
    return 64'(cycles) * 64'(clk_period_us) * 64'(SPEED_OF_LIGHT_HALF_M_PER_US);
  endfunction

endpackage

// File: rtl/artau_range_calc.sv
// Combinational echo-range and closing-target arithmetic; kept apart so the
// wide multiply/divide can be pipelined without touching the sequencer.
module artau_range_calc import artau_pkg::*; #(
  parameter int DATA_W        = 32,
  parameter int CLK_PERIOD_US = 50,
  parameter int CNT_W         = 5
) (
  input  logic [CNT_W-1:0]  listen_t_i,
  input  logic [DATA_W-1:0] elapsed_i,
  input  logic [DATA_W-1:0] jet_speed_i,
  input  logic [DATA_W-1:0] d_first_i,
  input  logic [DATA_W-1:0] max_safe_i,
  output logic [DATA_W-1:0] range_o,
  output logic              threat_o
);
  localparam int W2 = 2 * DATA_W;

  logic [DATA_W-1:0]        elapsed_us;
  logic [W2-1:0]            prod;
  logic signed [DATA_W+1:0] rel;

  always_comb begin
    range_o    = DATA_W'(range_from_cycles(32'(listen_t_i), 32'(CLK_PERIOD_US)));
    elapsed_us = elapsed_i * DATA_W'(CLK_PERIOD_US);
    prod       = W2'(jet_speed_i) * W2'(elapsed_us);
    // Own travel during the burst is added back so only target motion counts.
    rel        = $signed({2'b00, range_o})
               + $signed((DATA_W+2)'(prod / W2'(US_PER_S)))
               - $signed({2'b00, d_first_i});
    threat_o   = (range_o < max_safe_i) && (rel < $signed((DATA_W+2)'(0)));
  end

endmodule

// File: rtl/artau_burst_tracker.sv
// Burst radar sequencer: emits NUM_PULSES pulses, times each echo, and
// evaluates a closing-target threat once per completed burst.
module artau_burst_tracker import artau_pkg::*; #(
  parameter int DATA_W        = 32,
  parameter int NUM_PULSES    = 2,
  parameter int EMIT_CYCLES   = 3,
  parameter int LISTEN_CYCLES = 20,
  parameter int STATUS_CYCLES = 30,
  parameter int CLK_PERIOD_US = 50
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              radar_echo,
  input  logic              scan_for_target,
  input  logic [DATA_W-1:0] jet_speed,
  input  logic [DATA_W-1:0] max_safe_distance,
  output logic              radar_pulse_trigger,
  output logic [DATA_W-1:0] distance_to_target,
  output logic              threat_detected,
  output logic [1:0]        ARTAU_state,
  output logic [3:0]        pulse_index,
  output logic              burst_done
);
  localparam int MAX_A = (EMIT_CYCLES > LISTEN_CYCLES) ? EMIT_CYCLES : LISTEN_CYCLES;
  localparam int MAX_C = (MAX_A > STATUS_CYCLES) ? MAX_A : STATUS_CYCLES;
  localparam int CNT_W = $clog2(MAX_C + 1);

  artau_state_e      state_q;
  logic [CNT_W-1:0]  cnt_q;      // shared phase counter: only one phase runs at a time
  logic              echo_q;
  logic [DATA_W-1:0] elapsed_q, elapsed_d;
  logic [DATA_W-1:0] d_first_q, dist_q;
  logic              threat_q, trig_q, done_q;
  logic [3:0]        pidx_q;

  logic              echo_edge, last_pulse, calc_threat;
  logic [DATA_W-1:0] calc_range;

  assign echo_edge  = radar_echo & ~echo_q;
  assign last_pulse = (pidx_q == 4'(NUM_PULSES - 1));
  assign elapsed_d  = (&elapsed_q) ? elapsed_q : elapsed_q + 1'b1;

  // elapsed_d includes the cycle being sampled, as the threat rule requires.
  artau_range_calc #(
    .DATA_W(DATA_W), .CLK_PERIOD_US(CLK_PERIOD_US), .CNT_W(CNT_W)
  ) u_calc (
    .listen_t_i (cnt_q),
    .elapsed_i  (elapsed_d),
    .jet_speed_i(jet_speed),
    .d_first_i  (d_first_q),
    .max_safe_i (max_safe_distance),
    .range_o    (calc_range),
    .threat_o   (calc_threat)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      echo_q    <= 1'b0;
      elapsed_q <= '0;
      d_first_q <= '0;
      dist_q    <= '0;
      threat_q  <= 1'b0;
      trig_q    <= 1'b0;
      done_q    <= 1'b0;
      pidx_q    <= '0;
    end else begin
      echo_q <= radar_echo;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (scan_for_target) begin
            state_q   <= EMIT;
            cnt_q     <= CNT_W'(1);
            elapsed_q <= '0;
            trig_q    <= 1'b1;
          end
        end
        EMIT: begin
          elapsed_q <= elapsed_d;
          if (cnt_q == CNT_W'(EMIT_CYCLES)) begin
            state_q <= LISTEN;
            cnt_q   <= CNT_W'(1);
            trig_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        LISTEN: begin
          elapsed_q <= elapsed_d;
          if (echo_edge) begin
            dist_q <= calc_range;
            pidx_q <= pidx_q + 4'd1;
            if (pidx_q == 4'd0) d_first_q <= calc_range;
            if (last_pulse) begin
              state_q  <= STATUS;
              cnt_q    <= CNT_W'(1);
              threat_q <= calc_threat;
              done_q   <= 1'b1;
            end else begin
              state_q <= EMIT;
              cnt_q   <= CNT_W'(1);
              trig_q  <= 1'b1;
            end
          end else if (cnt_q == CNT_W'(LISTEN_CYCLES)) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dist_q   <= '0;
            threat_q <= 1'b0;
            pidx_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STATUS: begin
          // A rescan keeps the old verdict visible until the new burst decides.
          if (scan_for_target) begin
            state_q   <= EMIT;
            cnt_q     <= CNT_W'(1);
            elapsed_q <= '0;
            pidx_q    <= '0;
            trig_q    <= 1'b1;
          end else if (cnt_q == CNT_W'(STATUS_CYCLES)) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dist_q   <= '0;
            threat_q <= 1'b0;
            pidx_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign radar_pulse_trigger = trig_q;
  assign distance_to_target  = dist_q;
  assign threat_detected     = threat_q;
  assign ARTAU_state         = state_q;
  assign pulse_index         = pidx_q;
  assign burst_done          = done_q;

endmodule
